// File: rtl/puzzle3_line_scheduler.sv
// puzzle3_line_scheduler
//   Sequences battery-bank lines into the Puzzle 3 line core, one line in
//   flight at a time, and keeps the running total and line count.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | after reset; waits for run
//   WAIT_LINE  | line_ready high; waits for an upstream line
//   LAUNCH     | core_start pulse; watchdog cleared
//   WAIT_CORE  | waits for core_done; watchdog counting
//   ACCUM      | adds the captured BCD result to the total
//   DONE       | last line accumulated; result_valid high
//   ERR        | watchdog expiry or bad BCD digit; outputs held
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   run                 start / restart pulse (IDLE, DONE, ERR only)
//   line_valid/ready    upstream handshake; line_data, line_last payload
//   core_start          one-cycle launch pulse to the core
//   core_in_num         registered line, stable from LAUNCH through ACCUM
//   core_done           core completion pulse, core_result {tens, ones} BCD
//   total, line_count   running sum and number of accumulated lines
//   busy, result_valid  status
//   err_timeout, err_bcd, overflow  sticky flags, cleared by run
module puzzle3_line_scheduler #(
  parameter int IN_WIDTH       = 336,
  parameter int OUT_WIDTH      = 16,
  parameter int CNT_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 line_valid,
  output logic                 line_ready,
  input  logic [IN_WIDTH-1:0]  line_data,
  input  logic                 line_last,
  output logic                 core_start,
  output logic [IN_WIDTH-1:0]  core_in_num,
  input  logic                 core_done,
  input  logic [7:0]           core_result,
  output logic [OUT_WIDTH-1:0] total,
  output logic [CNT_WIDTH-1:0] line_count,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 err_timeout,
  output logic                 err_bcd,
  output logic                 overflow
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LINE, S_LAUNCH, S_WAIT_CORE, S_ACCUM, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [WD_W-1:0] wd_q;
  logic [7:0]      res_q;
  logic            last_q;

  logic clr_run, cap_line, clr_wd, cap_res, do_accum, set_tmo, set_bcd;

  logic [3:0]           tens, ones;
  logic [7:0]           tens8, value8;
  logic [OUT_WIDTH:0]   sum;
  logic                 bcd_bad;

  assign tens    = res_q[7:4];
  assign ones    = res_q[3:0];
  assign bcd_bad = (tens > 4'd9) || (ones > 4'd9);
  assign tens8   = {4'b0000, tens};
  assign value8  = (tens8 << 3) + (tens8 << 1) + {4'b0000, ones};
  // Extra top bit of the sum is the carry out that raises overflow.
  assign sum     = {1'b0, total} + {1'b0, OUT_WIDTH'(value8)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    line_ready   = 1'b0;
    core_start   = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    clr_run      = 1'b0;
    cap_line     = 1'b0;
    clr_wd       = 1'b0;
    cap_res      = 1'b0;
    do_accum     = 1'b0;
    set_tmo      = 1'b0;
    set_bcd      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        busy         = 1'b0;
        result_valid = (state_q == S_DONE);
        if (run) begin
          clr_run = 1'b1;
          state_d = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        line_ready = 1'b1;
        if (line_valid) begin
          cap_line = 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        clr_wd     = 1'b1;
        state_d    = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        // core_done takes priority over a simultaneous watchdog expiry.
        if (core_done) begin
          cap_res = 1'b1;
          state_d = S_ACCUM;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          set_tmo = 1'b1;
          state_d = S_ERR;
        end
      end
      S_ACCUM: begin
        if (bcd_bad) begin
          set_bcd = 1'b1;
          state_d = S_ERR;
        end else begin
          do_accum = 1'b1;
          state_d  = last_q ? S_DONE : S_WAIT_LINE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_in_num <= '0;
      last_q      <= 1'b0;
      wd_q        <= '0;
      res_q       <= '0;
      total       <= '0;
      line_count  <= '0;
      err_timeout <= 1'b0;
      err_bcd     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (clr_run) begin
        core_in_num <= '0;
        total       <= '0;
        line_count  <= '0;
        err_timeout <= 1'b0;
        err_bcd     <= 1'b0;
        overflow    <= 1'b0;
      end
      if (cap_line) begin
        core_in_num <= line_data;
        last_q      <= line_last;
      end
      if (clr_wd)                        wd_q <= '0;
      else if (state_q == S_WAIT_CORE)   wd_q <= wd_q + WD_W'(1);
      if (cap_res) res_q <= core_result;
      if (do_accum) begin
        total      <= sum[OUT_WIDTH-1:0];
        line_count <= line_count + CNT_WIDTH'(1);
        if (sum[OUT_WIDTH]) overflow <= 1'b1;
      end
      if (set_tmo) err_timeout <= 1'b1;
      if (set_bcd) err_bcd     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_puzzle3_line_scheduler.sv
// Testbench for puzzle3_line_scheduler. Two instances share all inputs:
//   dut a: OUT_WIDTH=16, TIMEOUT_CYCLES=16
//   dut b: OUT_WIDTH=8,  TIMEOUT_CYCLES=4
// The core is modelled by the bench, which pulses core_done a chosen
// number of WAIT_CORE cycles after observing core_start on dut a.
module tb_puzzle3_line_scheduler;

  localparam int IW = 336;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          line_valid = 1'b0;
  logic [IW-1:0] line_data = '0;
  logic          line_last = 1'b0;
  logic          core_done = 1'b0;
  logic [7:0]    core_result = '0;

  logic          line_ready_a, core_start_a, busy_a, result_valid_a;
  logic          err_timeout_a, err_bcd_a, overflow_a;
  logic [IW-1:0] core_in_num_a;
  logic [15:0]   total_a;
  logic [11:0]   line_count_a;

  logic          line_ready_b, core_start_b, busy_b, result_valid_b;
  logic          err_timeout_b, err_bcd_b, overflow_b;
  logic [IW-1:0] core_in_num_b;
  logic [7:0]    total_b;
  logic [11:0]   line_count_b;

  int n_total = 0;
  int n_bad   = 0;
  int starts  = 0;
  int hold_bad = 0;
  logic          hold_v = 1'b0;
  logic [IW-1:0] hold_d = '0;

  puzzle3_line_scheduler #(.IN_WIDTH(IW), .OUT_WIDTH(16), .CNT_WIDTH(12),
                           .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .run(run), .line_valid(line_valid),
    .line_ready(line_ready_a), .line_data(line_data), .line_last(line_last),
    .core_start(core_start_a), .core_in_num(core_in_num_a),
    .core_done(core_done), .core_result(core_result), .total(total_a),
    .line_count(line_count_a), .busy(busy_a), .result_valid(result_valid_a),
    .err_timeout(err_timeout_a), .err_bcd(err_bcd_a), .overflow(overflow_a));

  puzzle3_line_scheduler #(.IN_WIDTH(IW), .OUT_WIDTH(8), .CNT_WIDTH(12),
                           .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .run(run), .line_valid(line_valid),
    .line_ready(line_ready_b), .line_data(line_data), .line_last(line_last),
    .core_start(core_start_b), .core_in_num(core_in_num_b),
    .core_done(core_done), .core_result(core_result), .total(total_b),
    .line_count(line_count_b), .busy(busy_b), .result_valid(result_valid_b),
    .err_timeout(err_timeout_b), .err_bcd(err_bcd_b), .overflow(overflow_b));

  always #5 clk = ~clk;

  // core_start pulses and core_in_num stability from LAUNCH through ACCUM
  always @(negedge clk) begin
    if (core_start_a) starts <= starts + 1;
    if (busy_a && !line_ready_a) begin
      if (hold_v && core_in_num_a != hold_d) hold_bad <= hold_bad + 1;
      hold_v <= 1'b1;
      hold_d <= core_in_num_a;
    end else begin
      hold_v <= 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  function automatic logic [IW-1:0] rand_line();
    logic [IW-1:0] d;
    d = '0;
    for (int i = 0; i < IW; i += 16) d[i +: 16] = 16'($urandom);
    return d;
  endfunction

  // Hands one line over, then (if respond) returns res on the (lat+1)th
  // WAIT_CORE cycle. Returns one cycle after ACCUM, or in LAUNCH if !respond.
  task automatic send_line(input logic [IW-1:0] d, input bit last, input int gap,
                           input int lat, input logic [7:0] res, input bit respond);
    int guard;
    repeat (gap) step();
    line_valid = 1'b1;
    line_data  = d;
    line_last  = last;
    guard = 0;
    while (!line_ready_a && guard < 100) begin
      step();
      guard++;
    end
    if (!line_ready_a) begin
      n_total++;
      n_bad++;
      $display("FAIL handshake_wait actual=no_ready required=ready");
    end
    step();
    line_valid = 1'b0;
    line_last  = 1'b0;
    chk("launch_core_start", {31'd0, core_start_a}, 32'd1);
    chk("launch_in_num", core_in_num_a[31:0], d[31:0]);
    if (respond) begin
      step();
      repeat (lat) step();
      core_done   = 1'b1;
      core_result = res;
      step();
      core_done = 1'b0;
      step();
    end
  endtask

  typedef struct {
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [15:0] exp_total;
    logic [11:0] exp_cnt;
    bit          exp_bcd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0;
    logic [IW-1:0] d;

    vecs[0] = '{8'h98, 8'h01, 16'd99,  12'd2, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 16'd0,   12'd2, 1'b0};
    vecs[2] = '{8'h90, 8'h09, 16'd99,  12'd2, 1'b0};
    vecs[3] = '{8'h25, 8'h9A, 16'd25,  12'd1, 1'b1};
    vecs[4] = '{8'h37, 8'hA3, 16'd37,  12'd1, 1'b1};
    vecs[5] = '{8'h99, 8'h99, 16'd198, 12'd2, 1'b0};

    // reset state
    repeat (3) step();
    chk("rst_total", {16'd0, total_a}, 32'd0);
    chk("rst_count", {20'd0, line_count_a}, 32'd0);
    chk("rst_status", {26'd0, line_ready_a, core_start_a, busy_a, result_valid_a,
                       err_timeout_a, err_bcd_a}, 32'd0);
    chk("rst_in_num_zero", {31'd0, core_in_num_a == '0}, 32'd1);
    rst = 1'b1;
    step();
    chk("idle_ready", {31'd0, line_ready_a}, 32'd0);

    // single line, 5-cycle core
    s0 = starts;
    do_run();
    chk("wait_line_ready", {31'd0, line_ready_a}, 32'd1);
    send_line(rand_line(), 1'b1, 0, 4, 8'h98, 1'b1);
    chk("single_total", {16'd0, total_a}, 32'd98);
    chk("single_count", {20'd0, line_count_a}, 32'd1);
    chk("single_rv", {31'd0, result_valid_a}, 32'd1);
    chk("single_starts", starts - s0, 32'd1);

    // four lines with gaps; b has done on its watchdog expiry cycle
    s0 = starts;
    do_run();
    send_line(rand_line(), 1'b0, 0, 3, 8'h98, 1'b1);
    send_line(rand_line(), 1'b0, 1, 3, 8'h89, 1'b1);
    send_line(rand_line(), 1'b0, 2, 3, 8'h78, 1'b1);
    chk("three_total_b", {24'd0, total_b}, 32'd9);
    chk("three_ovf_b", {31'd0, overflow_b}, 32'd1);
    send_line(rand_line(), 1'b1, 3, 3, 8'h92, 1'b1);
    chk("four_total_a", {16'd0, total_a}, 32'd357);
    chk("four_count_a", {20'd0, line_count_a}, 32'd4);
    chk("four_ovf_a", {31'd0, overflow_a}, 32'd0);
    chk("four_total_b", {24'd0, total_b}, 32'd101);
    chk("four_tmo_b", {31'd0, err_timeout_b}, 32'd0);
    chk("four_rv_b", {31'd0, result_valid_b}, 32'd1);
    chk("four_starts", starts - s0, 32'd4);
    chk("in_num_stable", hold_bad, 32'd0);

    // table: two lines per run
    for (int i = 0; i < 6; i++) begin
      do_run();
      send_line(rand_line(), 1'b0, i % 3, i % 4, vecs[i].r0, 1'b1);
      send_line(rand_line(), 1'b1, 0, 2, vecs[i].r1, 1'b1);
      chk($sformatf("vec%0d_total", i), {16'd0, total_a}, {16'd0, vecs[i].exp_total});
      chk($sformatf("vec%0d_total_b", i), {24'd0, total_b}, {24'd0, vecs[i].exp_total[7:0]});
      chk($sformatf("vec%0d_count", i), {20'd0, line_count_a}, {20'd0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d_bcd", i), {31'd0, err_bcd_a}, {31'd0, vecs[i].exp_bcd});
      chk($sformatf("vec%0d_rv", i), {31'd0, result_valid_a}, {31'd0, !vecs[i].exp_bcd});
    end

    // watchdog expiry on dut a (16 cycles)
    do_run();
    chk("run_clears_bcd", {31'd0, err_bcd_a}, 32'd0);
    send_line(rand_line(), 1'b1, 0, 0, 8'h00, 1'b0);
    repeat (16) step();
    chk("tmo_not_yet", {31'd0, err_timeout_a}, 32'd0);
    chk("tmo_busy_before", {31'd0, busy_a}, 32'd1);
    step();
    chk("tmo_set", {31'd0, err_timeout_a}, 32'd1);
    chk("tmo_busy_after", {31'd0, busy_a}, 32'd0);
    step();
    chk("err_ready_low", {31'd0, line_ready_a}, 32'd0);
    do_run();
    chk("tmo_cleared", {31'd0, err_timeout_a}, 32'd0);
    send_line(rand_line(), 1'b1, 1, 1, 8'h12, 1'b1);
    chk("after_tmo_total", {16'd0, total_a}, 32'd12);

    // reset in WAIT_CORE, late core_done ignored
    do_run();
    send_line(rand_line(), 1'b0, 0, 0, 8'h00, 1'b1);
    send_line(rand_line(), 1'b0, 0, 0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b0;
    #2;
    chk("midrst_status", {28'd0, core_start_a, busy_a, line_ready_a, err_timeout_a}, 32'd0);
    chk("midrst_in_num_zero", {31'd0, core_in_num_a == '0}, 32'd1);
    chk("midrst_count", {20'd0, line_count_a}, 32'd0);
    step();
    rst = 1'b1;
    step();
    core_done   = 1'b1;
    core_result = 8'h55;
    step();
    core_done = 1'b0;
    step();
    chk("late_done_busy", {31'd0, busy_a}, 32'd0);
    chk("late_done_total", {16'd0, total_a}, 32'd0);
    do_run();
    send_line(rand_line(), 1'b1, 0, 2, 8'h45, 1'b1);
    chk("post_rst_total", {16'd0, total_a}, 32'd45);

    // randomized runs against an arithmetic reference model
    for (int r = 0; r < 12; r++) begin
      int n, acc16, acc8, cnt;
      bit ovf16, ovf8;
      n = $urandom_range(1, 5);
      acc16 = 0; acc8 = 0; cnt = 0; ovf16 = 0; ovf8 = 0;
      do_run();
      for (int k = 0; k < n; k++) begin
        int t, o, v;
        t = $urandom_range(0, 9);
        o = $urandom_range(0, 9);
        v = t * 10 + o;
        if (acc16 + v > 65535) ovf16 = 1;
        if (acc8 + v > 255) ovf8 = 1;
        acc16 = (acc16 + v) % 65536;
        acc8  = (acc8 + v) % 256;
        cnt++;
        d = rand_line();
        send_line(d, (k == n - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  {4'(t), 4'(o)}, 1'b1);
      end
      chk($sformatf("rnd%0d_total", r), {16'd0, total_a}, acc16);
      chk($sformatf("rnd%0d_total_b", r), {24'd0, total_b}, acc8);
      chk($sformatf("rnd%0d_count", r), {20'd0, line_count_a}, cnt);
      chk($sformatf("rnd%0d_ovf_b", r), {31'd0, overflow_b}, {31'd0, ovf8});
      chk($sformatf("rnd%0d_ovf_a", r), {31'd0, overflow_a}, {31'd0, ovf16});
      chk($sformatf("rnd%0d_rv", r), {31'd0, result_valid_a}, 32'd1);
    end
    chk("final_in_num_stable", hold_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
